// File: rtl/mem_access_unit.sv
// mem_access_unit: serialises one load/store request into big-endian byte accesses on a byte-wide memory port
module mem_access_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  input  logic [7:0]        req_wbyte,
  output logic              stall,
  output logic              done,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);
  typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d, byte_q, byte_d;
  logic [15:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]        wbyte_q, wbyte_d;
  logic              accept, in_hi, in_lo;
  assign accept = state_q == IDLE && req_valid;
  assign in_hi  = state_q == HI;
  assign in_lo  = state_q == LO;
  always_comb begin
    addr_d  = accept ? req_addr  : addr_q;
    write_d = accept ? req_write : write_q;
    byte_d  = accept ? req_byte  : byte_q;
    wdata_d = accept ? req_wdata : wdata_q;
    wbyte_d = accept ? req_wbyte : wbyte_q;
    state_d = accept ? ((req_write && req_byte) ? LO : HI) :
              in_hi  ? LO : in_lo ? DONE : IDLE;
    rdata_d = rdata_q;
    if (!write_q && in_hi) rdata_d[15:8] = mem_rdata;
    if (!write_q && in_lo) rdata_d[7:0]  = mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      wdata_q <= '0;
      wbyte_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      byte_q  <= byte_d;
      wdata_q <= wdata_d;
      wbyte_q <= wbyte_d;
      rdata_q <= rdata_d;
    end
  end
  // The low byte address wraps naturally at the address width.
  assign mem_addr  = in_hi ? addr_q : in_lo ? addr_q + ADDR_W'(1) : '0;
  assign mem_wdata = !write_q ? 8'h00 : in_hi ? wdata_q[15:8] :
                     in_lo ? (byte_q ? wbyte_q : wdata_q[7:0]) : 8'h00;
  assign mem_we    = !rst && write_q && (in_hi || in_lo);
  assign stall     = accept || in_hi || in_lo;
  assign done      = state_q == DONE;
  assign rdata     = rdata_q;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage initiator that turns one pipeline load/store request into byte-serial accesses on the byte-wide data memory port. Words are big-endian: the high byte is at `addr` and the low byte at `addr+1`. A store-offset (byte) store writes only `addr+1`. The block sits between the MEM pipeline stage and data memory, and stalls the pipeline until the access completes.

## Interface
- `ADDR_W`, 16, address width for request and memory addresses.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present; held by the pipeline while `stall`=1.
- `req_write`  in  1  1 = store, 0 = load.
- `req_byte`  in  1  store-offset: byte store to `req_addr+1` only. Ignored for loads.
- `req_addr`  in  ADDR_W  word address of the access.
- `req_wdata`  in  16  store data for word stores.
- `req_wbyte`  in  8  store data for byte stores.
- `stall`  out  1  pipeline must hold.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  16  last loaded word.
- `mem_addr`  out  ADDR_W  byte address to memory.
- `mem_wdata`  out  8  byte write data.
- `mem_we`  out  1  byte write enable; memory samples it on the rising edge.
- `mem_rdata`  in  8  combinational read data for `mem_addr`.

## Operation
- States: IDLE, HI, LO, DONE.
- **IDLE:** if `req_valid`=1, capture `req_addr`, `req_write`, `req_byte`, `req_wdata` and `req_wbyte`.
  - Byte store: go to LO.
  - Word load or word store: go to HI.
  - Otherwise stay in IDLE.
- **HI:**
  - `mem_addr`=captured addr.
  - Store: `mem_we`=1, `mem_wdata`=wdata[15:8].
  - Load: register `mem_rdata` into rdata[15:8].
  - Next state: LO.
- **LO:**
  - `mem_addr`=captured addr+1, computed modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000.
  - Word store: `mem_we`=1, `mem_wdata`=wdata[7:0].
  - Byte store: `mem_we`=1, `mem_wdata`=wbyte.
  - Load: register `mem_rdata` into rdata[7:0].
  - Next state: DONE.
- **DONE:**
  - `done`=1 and `stall`=0.
  - `req_valid` is ignored, because it is still the same instruction that advances at this edge.
  - Next state: IDLE.
- `stall` = (IDLE and `req_valid`) or HI or LO. It is combinational.
- `rdata` changes only on loads and holds its value across stores and idle cycles.
- `mem_addr` and `mem_wdata` are 0 in IDLE and DONE. `mem_we` is 0 outside HI and LO.
- `mem_we` is forced to 0 combinationally whenever `rst`=1.

## Timing
- Reset values after a `rst` edge:
  - state = IDLE.
  - `rdata` = 0x0000 and `done` = 0.
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `stall` = `req_valid`, because it is combinational.
- Word access, request first seen in cycle 0 (IDLE):
  - HI in cycle 1.
  - LO in cycle 2.
  - DONE in cycle 3.
  - `stall` high in cycles 0–2.
- Byte store: IDLE in cycle 0, LO in cycle 1, DONE in cycle 2. `stall` high in cycles 0–1.
- Load data is valid on `rdata` in the DONE cycle and holds afterwards.
- Back-to-back requests: the next request is accepted at the earliest in the IDLE cycle after DONE. There is no request gap penalty beyond the DONE cycle.
- Reset mid-operation aborts the access:
  - A partially completed word store may leave only the high byte written.
  - `rdata` returns to 0.
  - No `done` pulse is produced.
- `req_*` changes while `stall`=1 are a protocol violation. The block uses its captured copies, so such changes have no effect.

## Test plan
- **Word load:** memory[0x0000]=0x3C, memory[0x0001]=0xAD; load addr 0x0000.
  - Required: `mem_addr` 0x0000 then 0x0001.
  - Required: `done` in cycle 3, `rdata`=0x3CAD, `stall` high 3 cycles.
- **Word store:** 0x1234 to 0x0004.
  - Required: cycle 1 `mem_we`=1 with addr 0x0004, data 0x12.
  - Required: cycle 2 `mem_we`=1 with addr 0x0005, data 0x34.
  - Required: `rdata` unchanged.
- **Byte store:** wbyte 0x5A, `req_byte`=1, addr 0x0006, `req_wdata`=0xFFFF.
  - Required: a single write of 0x5A to 0x0007 and no write to 0x0006.
  - Required: `done` in cycle 2.
- **Wrap:** word load at 0xFFFF.
  - Required: second access at `mem_addr`=0x0000.
  - Required: `rdata`={mem[0xFFFF], mem[0x0000]}.
- **Reset mid-op:** assert `rst` in cycle 1 of a word store to 0x0008 (value 0xFEEB).
  - Required: `mem_we` low during the reset cycle and after it.
  - Required: state IDLE, no `done` pulse, `rdata`=0.
- **Back-to-back:** `req_valid` held high across DONE, followed by a new load.
  - Required: no re-acceptance in the DONE cycle.
  - Required: the second request starts in the following IDLE cycle, giving exactly two `done` pulses.
